// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave front end: 10-bit command frames in, RAM read byte out on MISO
module spi_slave #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int TXC_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 2);
  localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  typedef enum logic [1:0] {RX, WAIT_TX, SHIFT_OUT, DONE} sub_t;

  state_t state, next_state;
  sub_t   sub, next_sub;

  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] rx_shift;
  logic [DATA_W-1:0]  tx_shift;
  logic [TXC_W-1:0]   tx_cnt;
  logic               rd_addr_seen;

  logic receiving, frame_last, tx_load, shifting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sub   <= RX;
    end else begin
      state <= next_state;
      sub   <= next_sub;
    end
  end

  always_comb begin
    next_state = state;
    next_sub   = sub;
    // bit_cnt parks past LAST_CNT once a WRITE/READ_ADD frame is complete
    receiving  = (state == WRITE || state == READ_ADD ||
                  (state == READ_DATA && sub == RX)) && (bit_cnt <= LAST_CNT);
    frame_last = receiving && (bit_cnt == LAST_CNT) && !SS_n;
    // rx_valid still high means any tx_valid seen now predates this request
    tx_load    = (state == READ_DATA) && (sub == WAIT_TX) && tx_valid && !rx_valid && !SS_n;
    shifting   = (state == READ_DATA) && (sub == SHIFT_OUT) && !SS_n;

    if (state != IDLE && SS_n) begin
      next_state = IDLE;
      next_sub   = RX;
    end else begin
      case (state)
        IDLE: begin
          next_sub = RX;
          if (!SS_n) next_state = CHK_CMD;
        end
        CHK_CMD: begin
          next_sub = RX;
          if (!MOSI)             next_state = WRITE;
          else if (rd_addr_seen) next_state = READ_DATA;
          else                   next_state = READ_ADD;
        end
        READ_DATA: begin
          case (sub)
            RX:        if (frame_last) next_sub = WAIT_TX;
            WAIT_TX:   if (tx_load) next_sub = SHIFT_OUT;
            SHIFT_OUT: if (tx_cnt == TX_LAST) next_sub = DONE;
            default:   next_sub = DONE;
          endcase
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= frame_last;
      MISO     <= 1'b0;

      if (SS_n || state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == CHK_CMD) begin
        rx_shift <= {{(FRAME_W-2){1'b0}}, MOSI};
        bit_cnt  <= '0;
      end else if (receiving) begin
        rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
        bit_cnt  <= bit_cnt + 1'b1;
      end

      if (frame_last) begin
        rx_data <= {rx_shift, MOSI};
        if (state == READ_ADD)       rd_addr_seen <= 1'b1;
        else if (state == READ_DATA) rd_addr_seen <= 1'b0;
      end

      // rotate so bit 6 reaches the top on the edge after bit 7 is presented
      if (tx_load) begin
        tx_shift <= tx_data;
        MISO     <= tx_data[DATA_W-1];
        tx_cnt   <= '0;
      end else if (shifting && tx_cnt != TX_LAST) begin
        tx_shift <= {tx_shift[DATA_W-2:0], tx_shift[DATA_W-1]};
        MISO     <= tx_shift[DATA_W-2];
        tx_cnt   <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed table-driven bench for spi_slave
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  spi_slave #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] frame;
    logic       tx_v;
    logic [9:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns one cycle after the rx_valid pulse, SS_n still low
  task automatic frame_in(input logic [9:0] w, input logic [9:0] exp, input string nm);
    int early = 0;
    int miso_hi = 0;
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      tick();
      if (i > 0 && rx_valid) early++;
      if (MISO) miso_hi++;
    end
    chk({nm, " early rx_valid"}, early, 0);
    chk({nm, " miso during frame"}, miso_hi, 0);
    chk({nm, " rx_valid"}, rx_valid, 1);
    chk({nm, " rx_data"}, rx_data, exp);
    MOSI = 1'b0;
    tick();
    chk({nm, " rx_valid width"}, rx_valid, 0);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    tick();
  endtask

  task automatic shift_out(input logic [7:0] exp, input string nm);
    logic [7:0] got;
    for (int k = 0; k < 8; k++) begin
      got[7-k] = MISO;
      tick();
    end
    chk({nm, " miso byte"}, got, exp);
    chk({nm, " miso after byte"}, MISO, 0);
  endtask

  initial begin
    int cnt;

    vecs[0] = '{frame: 10'h05A, tx_v: 1'b0, exp_rx: 10'h05A};
    vecs[1] = '{frame: 10'h1C3, tx_v: 1'b1, exp_rx: 10'h1C3};
    vecs[2] = '{frame: 10'h000, tx_v: 1'b0, exp_rx: 10'h000};
    vecs[3] = '{frame: 10'h0FF, tx_v: 1'b1, exp_rx: 10'h0FF};
    vecs[4] = '{frame: 10'h155, tx_v: 1'b0, exp_rx: 10'h155};

    #2;
    chk("reset miso", MISO, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    #10 rst_n = 1'b1;
    tick();

    // write frames; trailing MOSI bits must be ignored while SS_n stays low
    for (int v = 0; v < 5; v++) begin
      tx_valid = vecs[v].tx_v;
      tx_data  = 8'hFF;
      frame_in(vecs[v].frame, vecs[v].exp_rx, $sformatf("vec%0d", v));
      cnt = 0;
      MOSI = 1'b1;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (rx_valid || MISO) cnt++;
      end
      chk($sformatf("vec%0d trailing bits", v), cnt, 0);
      end_frame();
      chk($sformatf("vec%0d miso idle", v), MISO, 0);
      tx_valid = 1'b0;
    end

    // abort after 6 bits, then a clean frame
    SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 4; i--) begin
      MOSI = 1'b1;
      tick();
    end
    SS_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (rx_valid) cnt++;
    end
    chk("abort6 rx_valid", cnt, 0);
    chk("abort6 rx_data held", rx_data, 10'h155);
    frame_in(10'h0A7, 10'h0A7, "after abort");
    end_frame();

    // abort on the same edge as bit 0
    SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 1; i--) begin
      MOSI = 1'b1;
      tick();
    end
    MOSI = 1'b0;
    SS_n = 1'b1;
    tick();
    chk("abort bit0 rx_valid", rx_valid, 0);
    tick();
    chk("abort bit0 rx_valid next", rx_valid, 0);
    chk("abort bit0 rx_data held", rx_data, 10'h0A7);

    // read address then read data, RAM answers after a delay
    frame_in(10'h25A, 10'h25A, "rd addr");
    end_frame();
    frame_in(10'h300, 10'h300, "rd data");
    tick();
    chk("rd wait miso a", MISO, 0);
    tick();
    chk("rd wait miso b", MISO, 0);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    shift_out(8'hC3, "rd C3");
    end_frame();

    // rd_addr_seen cleared: a 1-led frame is a READ_ADD again, no shift-out
    frame_in(10'h2AA, 10'h2AA, "rd addr2");
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (MISO) cnt++;
    end
    chk("readadd miso quiet", cnt, 0);
    end_frame();

    // stale tx_valid held across the whole READ_DATA frame
    tx_data = 8'h96;
    frame_in(10'h3FF, 10'h3FF, "stale");
    chk("stale not loaded early", MISO, 0);
    tick();
    tx_valid = 1'b0;
    shift_out(8'h96, "stale 96");
    end_frame();

    // asynchronous reset mid shift-out
    frame_in(10'h25A, 10'h25A, "rst addr");
    end_frame();
    frame_in(10'h3C0, 10'h3C0, "rst data");
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    chk("rst pre miso", MISO, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst miso", MISO, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst rx_data", rx_data, 0);
    SS_n = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    frame_in(10'h3AA, 10'h3AA, "post rst");
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (MISO) cnt++;
    end
    chk("post rst readadd quiet", cnt, 0);
    tx_valid = 1'b0;
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave front end that deserialises 10-bit command frames from an SPI master and hands them to the single-port RAM stage as a parallel word plus a one-cycle valid strobe. For read-data commands it waits for the RAM's returned byte and serialises it back on MISO. The SPI clock is the system clock `clk`. The block sits directly upstream of the RAM and consumes its read-data output.

Parameters:
- FRAME_W, 10, command frame width in bits (din[9:8] = command, din[7:0] = payload).
- DATA_W, 8, width of the read-data byte returned on MISO.

Ports:
- clk  input  1  system/SPI clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; a frame is one continuous low period.
- MOSI  input  1  serial data in, MSB (bit 9) first, sampled on the rising edge of clk.
- MISO  output  1  serial data out, MSB first; registered.
- rx_data  output  10  assembled frame to the RAM (RAM din).
- rx_valid  output  1  one-cycle strobe, rx_data valid (RAM rx_valid).
- tx_data  input  8  read byte from the RAM (RAM dout).
- tx_valid  input  1  RAM read-data valid (level).

Behaviour:
- Reset values: state IDLE, rx_data 0, rx_valid 0, MISO 0, bit counter 0, rd_addr_seen flag 0, tx shift register 0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - READ_DATA has sub-phases: RX, WAIT_TX, SHIFT_OUT, DONE.
- IDLE:
  - SS_n sampled low goes to CHK_CMD; otherwise stay.
  - MISO is 0.
- CHK_CMD: the MOSI sampled on this edge is frame bit 9 and is stored. Next state:
  - MOSI=0 goes to WRITE.
  - MOSI=1 and rd_addr_seen=0 goes to READ_ADD.
  - MOSI=1 and rd_addr_seen=1 goes to READ_DATA.
- WRITE / READ_ADD / READ_DATA(RX):
  - Shift in frame bits 8..0 on 9 consecutive edges, MSB first.
  - On the edge capturing bit 0, the full 10-bit word is loaded into rx_data.
  - rx_valid is 1 for exactly the following cycle, then returns to 0.
- Frame forwarding:
  - The word is forwarded unmodified; the command decode of din[9:8] belongs to the RAM.
  - The state only selects sequencing, so a READ_ADD frame whose bit 8 is 1 is still forwarded as-is.
- rd_addr_seen flag:
  - Set on the rx_valid pulse of a READ_ADD frame.
  - Cleared on the rx_valid pulse of a READ_DATA frame.
  - Not changed by SS_n aborts.
- WRITE / READ_ADD after the frame: the state holds and further MOSI bits are ignored until SS_n is high.
- READ_DATA after the rx_valid pulse, WAIT_TX:
  - The first edge with tx_valid=1, at or after the cycle following rx_valid, loads tx_data into the tx shift register.
  - tx_valid that is already high before the rx_valid pulse is ignored.
- SHIFT_OUT:
  - MISO presents tx bit 7 in the cycle after the load, then bits 6..0 on the next 7 cycles, one bit per cycle.
  - After bit 0, MISO is 0 and the sub-phase is DONE until SS_n is high.
- SS_n high on any edge in any non-IDLE state:
  - Next state is IDLE.
  - The bit counter is cleared, the partial frame is discarded, and rx_valid is 0.
  - MISO is 0 from the next cycle.
  - rx_data holds its last value.
- SS_n high on the same edge that captures bit 0: the abort wins, no rx_valid.
- MISO is 0 in every state except READ_DATA/SHIFT_OUT.
- Asynchronous reset mid-frame returns immediately to the reset values above.

Test Plan:
- Write-address frame: SS_n low, MOSI 0,0,0x5A MSB-first (10 bits) → rx_data=0x05A, rx_valid high exactly 1 cycle after the last bit; MISO stays 0.
- Write-data frame: MOSI 0,1,0xC3 → rx_data=0x1C3, one rx_valid pulse; SS_n high → IDLE next cycle.
- Read sequence:
  - Frame 1: MOSI 1,0,0x5A → rx_data=0x25A, rd_addr_seen=1.
  - Frame 2: MOSI 1,1,0x00 → rx_data=0x300.
  - RAM returns tx_data=0xC3 with tx_valid → MISO = 1,1,0,0,0,0,1,1 on 8 consecutive cycles starting the cycle after capture; rd_addr_seen=0.
- Abort: SS_n high after 6 bits of a write frame → no rx_valid, state IDLE; a following full frame 0x0A7 → rx_data=0x0A7 correctly.
- Stale tx_valid: tx_valid held high from the previous read before a new READ_DATA frame completes → the byte is loaded only after the new rx_valid pulse.
- Reset: assert rst_n low mid-READ_DATA shift-out → MISO=0, rx_valid=0, rx_data=0, rd_addr_seen=0 immediately; the next frame starting with 1 goes to READ_ADD.
